// File: rtl/m_mem_arbiter_pkg.sv
// Shared definitions for the IF/DM single-port RAM arbiter: default widths,
// the killed-fetch filler word and the response-owner state encodings.
package m_mem_arbiter_pkg;

    localparam int unsigned ARB_ADDR_W     = 11;
    localparam int unsigned ARB_DATA_W     = 32;
    localparam int unsigned ARB_STARVE_MAX = 4;
    localparam logic [31:0] ARB_NOP_WORD   = 32'h0000_0020;

    // Owner of the word the RAM presents on its output in the current cycle
    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_DM   = 2'd2
    } rsp_e;

endpackage

// File: rtl/m_mem_arbiter.sv
// Arbiter sharing one synchronous single-port RAM between the fetch (IF) port
// and the load/store (DM) port. DM normally has priority; read data comes back
// one cycle after the grant and is steered to its owner. A taken branch turns
// the in-flight fetch response into a NOP.
// Optional feature: define ARB_STARVE_GUARD_EN to force an IF grant after
// STARVE_MAX consecutive denied fetch cycles.
module m_mem_arbiter
    import m_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ARB_ADDR_W,
    parameter int unsigned DATA_W     = ARB_DATA_W,
    parameter int unsigned STARVE_MAX = ARB_STARVE_MAX,
    parameter logic [DATA_W-1:0] NOP_WORD = ARB_NOP_WORD
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_if_req,
    input  logic [ADDR_W-1:0] w_if_addr,
    input  logic              w_if_kill,
    output logic              w_if_gnt,
    output logic              w_if_stall,
    output logic              r_if_vld,
    output logic [DATA_W-1:0] w_if_rdata,
    input  logic              w_dm_req,
    input  logic              w_dm_we,
    input  logic [ADDR_W-1:0] w_dm_addr,
    input  logic [DATA_W-1:0] w_dm_wdata,
    output logic              w_dm_gnt,
    output logic              r_dm_vld,
    output logic [DATA_W-1:0] w_dm_rdata,
    output logic [ADDR_W-1:0] w_mem_addr,
    output logic              w_mem_we,
    output logic [DATA_W-1:0] w_mem_din,
    input  logic [DATA_W-1:0] w_mem_dout
);

    rsp_e r_rsp;
    rsp_e rsp_next;
    logic r_kill;
    logic starve_force;

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] r_starve;

    // Count cycles a fetch waits in vain; any IF grant or idle IF clears it
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_starve <= 3'd0;
        end else if (!w_if_req || w_if_gnt) begin
            r_starve <= 3'd0;
        end else if (r_starve != 3'(STARVE_MAX)) begin
            r_starve <= r_starve + 3'd1;
        end
    end

    assign starve_force = w_if_req && (r_starve == 3'(STARVE_MAX));
`else
    assign starve_force = 1'b0;
`endif

    // Grant selection, RAM command mux and next response owner
    always_comb begin
        w_dm_gnt   = w_dm_req & ~starve_force;
        w_if_gnt   = w_if_req & (~w_dm_req | starve_force);
        w_if_stall = w_if_req & ~w_if_gnt;
        w_mem_addr = '0;
        w_mem_we   = 1'b0;
        w_mem_din  = '0;
        rsp_next   = RSP_NONE;
        if (w_dm_gnt) begin
            w_mem_addr = w_dm_addr;
            w_mem_we   = w_dm_we & w_rst_n;
            w_mem_din  = w_dm_wdata;
            if (!w_dm_we) begin
                rsp_next = RSP_DM;
            end
        end else if (w_if_gnt) begin
            w_mem_addr = w_if_addr;
            rsp_next   = RSP_IF;
        end
    end

    // Response owner register; r_kill remembers a kill that arrived together
    // with its own fetch grant, so the response one cycle later is replaced
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_rsp    <= RSP_NONE;
            r_if_vld <= 1'b0;
            r_dm_vld <= 1'b0;
            r_kill   <= 1'b0;
        end else begin
            r_rsp    <= rsp_next;
            r_if_vld <= (rsp_next == RSP_IF);
            r_dm_vld <= (rsp_next == RSP_DM);
            r_kill   <= w_if_kill & w_if_gnt;
        end
    end

    // A kill arriving while the fetch response is on the bus replaces it at
    // once; a kill registered with its grant replaces it one cycle later
    always_comb begin
        w_if_rdata = w_mem_dout;
        if (r_kill || (w_if_kill && (r_rsp == RSP_IF))) begin
            w_if_rdata = NOP_WORD;
        end
        w_dm_rdata = w_mem_dout;
    end

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Directed self-checking bench for m_mem_arbiter with a behavioural
// read-first 2K x 32 RAM. Honours ARB_STARVE_GUARD_EN for the starvation case.
module tb_m_mem_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam logic [31:0] NOP = 32'h0000_0020;
`ifdef ARB_STARVE_GUARD_EN
    localparam int IF_WIN = 5;
`else
    localparam int IF_WIN = 9;
`endif

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_kill;
    logic          if_gnt;
    logic          if_stall;
    logic          if_vld;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_vld;
    logic [DW-1:0] dm_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] ram [0:2047];

    int vectors;
    int miscompares;

    m_mem_arbiter dut (
        .w_clk      (clk),
        .w_rst_n    (rst_n),
        .w_if_req   (if_req),
        .w_if_addr  (if_addr),
        .w_if_kill  (if_kill),
        .w_if_gnt   (if_gnt),
        .w_if_stall (if_stall),
        .r_if_vld   (if_vld),
        .w_if_rdata (if_rdata),
        .w_dm_req   (dm_req),
        .w_dm_we    (dm_we),
        .w_dm_addr  (dm_addr),
        .w_dm_wdata (dm_wdata),
        .w_dm_gnt   (dm_gnt),
        .r_dm_vld   (dm_vld),
        .w_dm_rdata (dm_rdata),
        .w_mem_addr (mem_addr),
        .w_mem_we   (mem_we),
        .w_mem_din  (mem_din),
        .w_mem_dout (mem_dout)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read-first synchronous RAM with a bench-only preload path
    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_din;
        end
        mem_dout <= ram[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ireq, input logic [AW-1:0] iaddr, input logic ikill,
                                 input logic dreq, input logic dwe, input logic [AW-1:0] daddr,
                                 input logic [DW-1:0] dwdata);
        if_req   = ireq;
        if_addr  = iaddr;
        if_kill  = ikill;
        dm_req   = dreq;
        dm_we    = dwe;
        dm_addr  = daddr;
        dm_wdata = dwdata;
    endtask

    initial begin
        logic [AW-1:0] pa [7];
        logic [DW-1:0] pd [7];
        logic          if_pending;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        pre_en      = 1'b0;
        pre_addr    = '0;
        pre_data    = '0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        pa = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5, 11'd9};
        pd = '{32'd100, 32'd101, 32'd102, 32'd103, 32'h1234, 32'd500, 32'd900};

        // Preload RAM while the arbiter is held in reset
        step();
        pre_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            pre_addr = pa[i];
            pre_data = pd[i];
            step();
        end
        pre_en = 1'b0;

        // Reset state: no responses, store request must not reach the RAM
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 11'd3, 32'hBAD0_BAD0);
        settle();
        checkOutput("rst_if_vld", {31'd0, if_vld}, 32'd0);
        checkOutput("rst_dm_vld", {31'd0, dm_vld}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        settle();
        checkOutput("idle_mem_addr", {21'd0, mem_addr}, 32'd0);

        // 1: back-to-back fetches of addresses 0..3
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i < 4, AW'(i), 1'b0, 1'b0, 1'b0, '0, '0);
            settle();
            checkOutput("t1_if_gnt", {31'd0, if_gnt}, {31'd0, i < 4});
            checkOutput("t1_if_vld", {31'd0, if_vld}, {31'd0, i > 0});
            if (i > 0) checkOutput("t1_if_rdata", if_rdata, 32'(100 + i - 1));
            step();
        end

        // 2: IF and DM load collide; DM first, IF next cycle
        applyStimulus(1'b1, 11'd5, 1'b0, 1'b1, 1'b0, 11'd9, '0);
        settle();
        checkOutput("t2_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        checkOutput("t2_if_gnt", {31'd0, if_gnt}, 32'd0);
        checkOutput("t2_if_stall", {31'd0, if_stall}, 32'd1);
        checkOutput("t2_mem_addr", {21'd0, mem_addr}, 32'd9);
        step();
        applyStimulus(1'b1, 11'd5, 1'b0, 1'b0, 1'b0, '0, '0);
        settle();
        checkOutput("t2_if_gnt2", {31'd0, if_gnt}, 32'd1);
        checkOutput("t2_mem_addr2", {21'd0, mem_addr}, 32'd5);
        checkOutput("t2_dm_vld", {31'd0, dm_vld}, 32'd1);
        checkOutput("t2_dm_rdata", dm_rdata, 32'd900);
        checkOutput("t2_if_vld0", {31'd0, if_vld}, 32'd0);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        settle();
        checkOutput("t2_if_vld", {31'd0, if_vld}, 32'd1);
        checkOutput("t2_if_rdata", if_rdata, 32'd500);
        checkOutput("t2_dm_vld0", {31'd0, dm_vld}, 32'd0);
        step();

        // 3: store then load of the same address
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 11'd7, 32'hDEAD_BEEF);
        settle();
        checkOutput("t3_mem_we", {31'd0, mem_we}, 32'd1);
        checkOutput("t3_mem_din", mem_din, 32'hDEAD_BEEF);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 11'd7, '0);
        settle();
        checkOutput("t3_store_no_vld", {31'd0, dm_vld}, 32'd0);
        checkOutput("t3_load_we", {31'd0, mem_we}, 32'd0);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        settle();
        checkOutput("t3_dm_vld", {31'd0, dm_vld}, 32'd1);
        checkOutput("t3_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
        step();

        // 4a: kill while the fetch response is on the bus
        applyStimulus(1'b1, 11'd4, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        settle();
        checkOutput("t4_if_vld", {31'd0, if_vld}, 32'd1);
        checkOutput("t4_if_rdata", if_rdata, NOP);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        settle();
        checkOutput("t4_if_vld0", {31'd0, if_vld}, 32'd0);
        // 4b: kill in the same cycle as the grant
        applyStimulus(1'b1, 11'd4, 1'b1, 1'b0, 1'b0, '0, '0);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        settle();
        checkOutput("t4b_if_vld", {31'd0, if_vld}, 32'd1);
        checkOutput("t4b_if_rdata", if_rdata, NOP);
        step();
        // 4c: kill with nothing in flight has no effect on the next fetch
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, 11'd9, '0);
        step();
        applyStimulus(1'b1, 11'd4, 1'b0, 1'b0, 1'b0, '0, '0);
        settle();
        checkOutput("t4c_dm_rdata", dm_rdata, 32'd900);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        settle();
        checkOutput("t4c_if_rdata", if_rdata, 32'h1234);
        step();

        // 5: DM request held for 8 cycles against a waiting fetch
        if_pending = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(if_pending, 11'd1, 1'b0, c <= 8, 1'b0, 11'd2, '0);
            settle();
            checkOutput("t5_if_gnt", {31'd0, if_gnt}, {31'd0, c == IF_WIN});
            checkOutput("t5_dm_gnt", {31'd0, dm_gnt}, {31'd0, (c <= 8) && (c != IF_WIN)});
            checkOutput("t5_if_vld", {31'd0, if_vld}, {31'd0, c == IF_WIN + 1});
            checkOutput("t5_dm_vld", {31'd0, dm_vld},
                        {31'd0, (c >= 2) && (c - 1 <= 8) && (c - 1 != IF_WIN)});
            if (c == IF_WIN + 1) checkOutput("t5_if_rdata", if_rdata, 32'd101);
            step();
            if (c == IF_WIN) if_pending = 1'b0;
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();

        // 6: reset arriving while a load response is pending
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 11'd9, '0);
        settle();
        checkOutput("t6_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        step();
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 11'd3, 32'hBAD0_BAD0);
        settle();
        checkOutput("t6_we_in_rst", {31'd0, mem_we}, 32'd0);
        step();
        settle();
        checkOutput("t6_dm_vld_rst", {31'd0, dm_vld}, 32'd0);
        checkOutput("t6_if_vld_rst", {31'd0, if_vld}, 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 11'd3, '0);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        settle();
        checkOutput("t6_dm_vld", {31'd0, dm_vld}, 32'd1);
        checkOutput("t6_no_write", dm_rdata, 32'd103);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
